fp4_int4_mac_array: RTL

- Parametrised successor to the single-mode FP4 x INT8 systolic array.
- Accumulates a 2*SLICES x SLICES matrix product from byte-streamed inputs, with two left-operand formats selected per tile: FP4 e3m0 or signed INT4.
- Adds an explicit input valid, a drain/readout handshake with out_valid, and a saturating, configurable-shift output.
- Sits between the tile top-level pins and the host readout stream.

---
 rtl/fp4_int4_mac_array_if.sv | 21 ++
 rtl/fp4_int4_mac_array.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fp4_int4_mac_array_if.sv
// rtl/fp4_int4_mac_array_if.sv - operand beat, readout request and result stream bundle
interface fp4_int4_mac_array_if;
  logic       in_valid;
  logic [7:0] in_left;
  logic [7:0] in_top;
  logic       mode;
  logic       start_readout;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;

  modport master (
    output in_valid, in_left, in_top, mode, start_readout,
    input  out, out_valid, busy
  );

  modport slave (
    input  in_valid, in_left, in_top, mode, start_readout,
    output out, out_valid, busy
  );
endinterface

// File: rtl/fp4_int4_mac_array.sv
// rtl/fp4_int4_mac_array.sv - 2*SLICES x SLICES FP4/INT4 x INT8 accumulating array with drained readout
module fp4_int4_mac_array #(
  parameter int SLICES    = 4,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 11
) (
  input logic                 clk,
  input logic                 rst_n,
  fp4_int4_mac_array_if.slave bus
);
  localparam int H  = 2 * SLICES;
  localparam int W  = SLICES;
  localparam int N  = H * W;
  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int RW = $clog2(N);
  localparam int NW = $clog2(N + 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                  state;
  logic [KW-1:0]           k;
  logic [KW-1:0]           c;
  logic                    flush_pend;
  logic                    comp_on;
  logic                    mode_curr;
  logic [3:0]              left_next [H];
  logic [3:0]              left_curr [H];
  logic [7:0]              top_next  [W];
  logic [7:0]              top_curr  [W];
  logic signed [ACC_W-1:0] acc       [H][W];
  logic [7:0]              q         [N];
  logic [NW-1:0]           q_cnt;
  logic [RW-1:0]           rd;

  logic last_beat, q_nz, rd_req, beat_ok, do_copy;

  function automatic logic signed [ACC_W-1:0] prod(input logic [3:0] w, input logic [7:0] x,
                                                   input logic int4);
    logic signed [ACC_W-1:0] xs, ws, sh;
    xs = {{(ACC_W-8){x[7]}}, x};
    ws = {{(ACC_W-4){w[3]}}, w};
    sh = xs <<< w[2:0];
    if (int4)
      prod = xs * ws;
    else if (w[2:0] == 3'd0)
      prod = '0;
    else
      prod = w[3] ? -sh : sh;
  endfunction

  function automatic logic [7:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> OUT_SHIFT;
    if (s > ACC_W'(127))
      sat = 8'h7f;
    else if (s < ACC_W'(-128))
      sat = 8'h80;
    else
      sat = s[7:0];
  endfunction

  assign last_beat = (k == KW'(SLICES - 1));
  assign q_nz      = (q_cnt != '0);
  assign rd_req    = bus.start_readout && (state == RUN) && !q_nz;
  // A readout request only lets the beat through when it completes a tile.
  assign beat_ok   = bus.in_valid && (state == RUN) && (!rd_req || last_beat);
  assign do_copy   = (state == DRAIN) && !comp_on && !flush_pend;

  assign bus.out_valid = q_nz;
  assign bus.out       = q_nz ? q[rd] : 8'd0;
  assign bus.busy      = (state == DRAIN) || q_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      k          <= '0;
      c          <= '0;
      flush_pend <= 1'b0;
      comp_on    <= 1'b0;
      mode_curr  <= 1'b0;
      for (int i = 0; i < H; i++) begin
        left_next[i] <= '0;
        left_curr[i] <= '0;
      end
      for (int j = 0; j < W; j++) begin
        top_next[j] <= '0;
        top_curr[j] <= '0;
      end
    end else begin
      flush_pend <= beat_ok && last_beat;

      if (beat_ok) begin
        left_next[{k, 1'b0}] <= bus.in_left[3:0];
        left_next[{k, 1'b1}] <= bus.in_left[7:4];
        top_next[k]          <= bus.in_top;
        k                    <= last_beat ? '0 : k + 1'b1;
      end else if (state == DRAIN || rd_req) begin
        k <= '0;
      end

      // Flush wins over the last compute column so back-to-back tiles never stall.
      if (flush_pend) begin
        left_curr <= left_next;
        top_curr  <= top_next;
        mode_curr <= bus.mode;
        comp_on   <= 1'b1;
        c         <= '0;
      end else if (comp_on) begin
        if (c == KW'(W - 1))
          comp_on <= 1'b0;
        else
          c <= c + 1'b1;
      end

      if (state == RUN && rd_req)
        state <= DRAIN;
      else if (do_copy)
        state <= RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++)
          acc[i][j] <= '0;
      for (int n = 0; n < N; n++)
        q[n] <= '0;
      q_cnt <= '0;
      rd    <= '0;
    end else begin
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++)
          if (do_copy)
            acc[i][j] <= '0;
          else if (comp_on && c == KW'(j))
            acc[i][j] <= acc[i][j] + prod(left_curr[i], top_curr[j], mode_curr);

      if (do_copy) begin
        for (int i = 0; i < H; i++)
          for (int j = 0; j < W; j++)
            q[i*W + j] <= sat(acc[i][j]);
        q_cnt <= NW'(N);
        rd    <= '0;
      end else if (q_nz) begin
        q_cnt <= q_cnt - 1'b1;
        rd    <= rd + 1'b1;
      end
    end
  end
endmodule
